// File: rtl/bitcount_sequencer.sv
// Feeds queued operands to the ASMD bit-counter over the s/done handshake and
// accumulates the returned counts into a saturating total with sticky error flags.
module bitcount_sequencer #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 4,
    parameter int TOTAL_W   = 8,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               done,
    input  logic [CNT_W-1:0]   count,
    output logic [DATA_W-1:0]  A,
    output logic               s,
    output logic [CNT_W-1:0]   last_count,
    output logic [TOTAL_W-1:0] total,
    output logic               busy,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               timeout_err
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int TMR_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, START, CAPTURE, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic               s_q, s_d;
    logic [CNT_W-1:0]   last_count_q, last_count_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               overflow_q, overflow_d;
    logic               timeout_err_q, timeout_err_d;
    logic               push, pop;
    logic [TOTAL_W:0]   sum;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_W'(DEPTH));

    // FIFO: full is the registered occupancy, so a load while full is dropped
    // even when the FSM pops in the same cycle.
    always_comb begin
        push       = load && !full;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q | (load & full);
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        a_d           = a_q;
        s_d           = s_q;
        pop           = 1'b0;
        last_count_d  = last_count_q;
        total_d       = total_q;
        timeout_err_d = timeout_err_q;
        sum           = {1'b0, total_q} + (TOTAL_W + 1)'(count);
        case (state_q)
            IDLE: begin
                s_d = 1'b0;
                if (!empty) begin
                    a_d     = mem_q[rd_ptr_q];
                    timer_d = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (timer_q == TMR_W'(SETUP_CYC - 1)) begin
                    timer_d = '0;
                    s_d     = 1'b1;
                    state_d = START;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            START: begin
                timer_d = timer_q + 1'b1;
                if (done) begin
                    state_d = CAPTURE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    pop           = 1'b1;
                    s_d           = 1'b0;
                    state_d       = RELEASE;
                end
            end
            CAPTURE: begin
                last_count_d = count;
                total_d      = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
                pop          = 1'b1;
                s_d          = 1'b0;
                state_d      = RELEASE;
            end
            RELEASE: begin
                // Controller holds done until it sees s low; wait it out.
                if (!done) state_d = IDLE;
            end
            default: begin
                s_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            timer_q       <= '0;
            a_q           <= '0;
            s_q           <= 1'b0;
            last_count_q  <= '0;
            total_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            timer_q       <= timer_d;
            a_q           <= a_d;
            s_q           <= s_d;
            last_count_q  <= last_count_d;
            total_q       <= total_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign A           = a_q;
    assign s           = s_q;
    assign last_count  = last_count_q;
    assign total       = total_q;
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
endmodule
